conv_interleaver: RTL and testbench

- Parametrised convolutional (Forney) interleaver/deinterleaver for the byte-stream path.
- Generalises the fixed 17-stage, 8-bit delay line to BRANCHES branches; branch delays are multiples of DEPTH_UNIT symbols.
- A rotating commutator steers one symbol per valid cycle into a branch. Branch storage advances only when its branch is visited.
- A runtime mode input selects interleave or deinterleave, so one block serves both ends of the link.

---
 rtl/conv_interleaver_if.sv | 28 ++
 rtl/conv_interleaver.sv | 87 ++++++++
 tb/tb_conv_interleaver.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_interleaver_if.sv
// Symbol stream bundle for the convolutional interleaver.
// master: drives in_valid/in_data/in_sync/deint, receives out_*.
// slave : receives in_*/deint, drives out_valid/out_data/out_sync/out_branch.
interface conv_interleaver_if #(
    parameter int WIDTH    = 8,
    parameter int BRANCHES = 12
);
    localparam int BW = $clog2(BRANCHES);

    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_sync;
    logic             deint;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_sync;
    logic [BW-1:0]    out_branch;

    modport master (
        output in_valid, in_data, in_sync, deint,
        input  out_valid, out_data, out_sync, out_branch
    );

    modport slave (
        input  in_valid, in_data, in_sync, deint,
        output out_valid, out_data, out_sync, out_branch
    );
endinterface

// File: rtl/conv_interleaver.sv
// Forney convolutional interleaver/deinterleaver with runtime mode select.
// Ports: clk, reset (async active-low), bus (slave: in_* / deint in, out_* out).
module conv_interleaver #(
    parameter int WIDTH      = 8,
    parameter int BRANCHES   = 12,
    parameter int DEPTH_UNIT = 17
) (
    input  logic                clk,
    input  logic                reset,
    conv_interleaver_if.slave   bus
);
    localparam int MAXD = (BRANCHES - 1) * DEPTH_UNIT;
    localparam int BW   = $clog2(BRANCHES);
    localparam int DW   = $clog2(MAXD + 1);

    logic [BW-1:0]    ptr_q;
    logic [BW-1:0]    br;
    logic [BW-1:0]    ptr_d;
    logic             mode_q;
    logic             mode_eff;
    logic [DW-1:0]    dly;
    logic [WIDTH-1:0] tap;
    logic [WIDTH-1:0] row   [MAXD];
    logic [WIDTH-1:0] mem_q [BRANCHES][MAXD];

    logic             ov_q;
    logic [WIDTH-1:0] od_q;
    logic             os_q;
    logic [BW-1:0]    ob_q;

    // Each branch is a shift chain sized for the largest delay; the active
    // delay only picks the tap, so a mode switch keeps stored symbols.
    always_comb begin
        br       = bus.in_sync ? '0 : ptr_q;
        ptr_d    = (br == BW'(BRANCHES - 1)) ? '0 : br + BW'(1);
        // a sync symbol already travels under the mode it loads
        mode_eff = bus.in_sync ? bus.deint : mode_q;
        if (mode_eff)
            dly = DW'((BRANCHES - 1 - int'(br)) * DEPTH_UNIT);
        else
            dly = DW'(int'(br) * DEPTH_UNIT);
        row = mem_q[0];
        for (int b = 1; b < BRANCHES; b++)
            if (br == BW'(b))
                row = mem_q[b];
        tap = bus.in_data;
        for (int i = 0; i < MAXD; i++)
            if (dly == DW'(i + 1))
                tap = row[i];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q  <= '0;
            mode_q <= 1'b0;
            ov_q   <= 1'b0;
            od_q   <= '0;
            os_q   <= 1'b0;
            ob_q   <= '0;
            for (int b = 0; b < BRANCHES; b++)
                for (int i = 0; i < MAXD; i++)
                    mem_q[b][i] <= '0;
        end else begin
            ov_q <= bus.in_valid;
            if (bus.in_valid) begin
                ptr_q <= ptr_d;
                if (bus.in_sync)
                    mode_q <= bus.deint;
                od_q <= tap;
                os_q <= (br == '0);
                ob_q <= br;
                for (int b = 0; b < BRANCHES; b++) begin
                    if (br == BW'(b)) begin
                        for (int i = MAXD - 1; i > 0; i--)
                            mem_q[b][i] <= mem_q[b][i-1];
                        mem_q[b][0] <= bus.in_data;
                    end
                end
            end
        end
    end

    assign bus.out_valid  = ov_q;
    assign bus.out_data   = od_q;
    assign bus.out_sync   = os_q;
    assign bus.out_branch = ob_q;
endmodule

// File: tb/tb_conv_interleaver.sv
// Bench for conv_interleaver: small config vs queue model, chained
// deinterleaver end-to-end delay, and default-parameter fill/lag.
module tb_conv_interleaver;
    localparam int NB  = 3;
    localparam int DU  = 2;
    localparam int E2E = (NB - 1) * DU * NB;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b1;

    conv_interleaver_if #(.WIDTH(8), .BRANCHES(NB)) bus_a ();
    conv_interleaver_if #(.WIDTH(8), .BRANCHES(NB)) bus_b ();
    conv_interleaver_if bus_c ();

    conv_interleaver #(.WIDTH(8), .BRANCHES(NB), .DEPTH_UNIT(DU)) u_a (
        .clk(clk), .reset(rst_n), .bus(bus_a)
    );
    conv_interleaver #(.WIDTH(8), .BRANCHES(NB), .DEPTH_UNIT(DU)) u_b (
        .clk(clk), .reset(rst_n), .bus(bus_b)
    );
    conv_interleaver u_c (
        .clk(clk), .reset(rst_n), .bus(bus_c)
    );

    assign bus_b.in_valid = bus_a.out_valid;
    assign bus_b.in_data  = bus_a.out_data;
    assign bus_b.in_sync  = bus_a.out_sync;
    assign bus_b.deint    = 1'b1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // reference model: one FIFO per branch holding exactly delay(b) symbols
    int         m_ptr;
    bit         m_mode;
    logic [7:0] mq [NB][$];

    function automatic int dly_of(input int b, input bit m);
        return m ? (NB - 1 - b) * DU : b * DU;
    endfunction

    task automatic mdl_fill(input bit m);
        m_mode = m;
        for (int b = 0; b < NB; b++) begin
            mq[b].delete();
            repeat (dly_of(b, m)) mq[b].push_back(8'd0);
        end
    endtask

    logic [7:0] src [$];
    logic [7:0] obs [$];
    int         obr [$];
    bit         osy [$];
    int         nb;
    int         b_first;
    bit         chk_b;

    task automatic step(input bit v, input logic [7:0] d, input bit s,
                        input bit dm);
        bit         es;
        logic [7:0] ed;
        int         eb;
        int         br;
        logic [7:0] bexp;
        es = 1'b0;
        ed = 8'd0;
        eb = 0;
        if (v) begin
            br = s ? 0 : m_ptr;
            if (s && dm != m_mode)
                mdl_fill(dm);
            if (dly_of(br, m_mode) == 0) begin
                ed = d;
            end else begin
                ed = mq[br].pop_front();
                mq[br].push_back(d);
            end
            m_ptr = (br + 1) % NB;
            es = (br == 0);
            eb = br;
            src.push_back(d);
        end
        bus_a.in_valid = v;
        bus_a.in_data  = d;
        bus_a.in_sync  = s;
        bus_a.deint    = dm;
        @(posedge clk);
        #1;
        bus_a.in_valid = 1'b0;
        bus_a.in_sync  = 1'b0;
        chk("a_valid", bus_a.out_valid, v);
        if (v) begin
            chk("a_data", bus_a.out_data, ed);
            chk("a_sync", bus_a.out_sync, es);
            chk("a_branch", bus_a.out_branch, eb);
            obs.push_back(bus_a.out_data);
            obr.push_back(int'(bus_a.out_branch));
            osy.push_back(bus_a.out_sync);
        end
        if (chk_b && bus_b.out_valid) begin
            bexp = (nb >= E2E) ? src[nb - E2E] : 8'd0;
            chk("b_data", bus_b.out_data, bexp);
            if (bus_b.out_data != 0 && b_first < 0)
                b_first = nb;
            nb++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = 8'h55;
        #1;
        chk("rst_a_valid", bus_a.out_valid, 0);
        chk("rst_a_data", bus_a.out_data, 0);
        chk("rst_a_sync", bus_a.out_sync, 0);
        chk("rst_a_branch", bus_a.out_branch, 0);
        chk("rst_c_valid", bus_c.out_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_valid", bus_a.out_valid, 0);
        chk("rst_hold_data", bus_a.out_data, 0);
        bus_a.in_valid = 1'b0;
        rst_n = 1'b1;
        m_ptr = 0;
        mdl_fill(1'b0);
        src.delete();
        obs.delete();
        obr.delete();
        osy.delete();
        nb = 0;
        b_first = -1;
    endtask

    task automatic chk_first9(input string tag);
        logic [7:0] ref9 [9];
        ref9 = '{8'd1, 8'd0, 8'd0, 8'd4, 8'd0, 8'd0, 8'd7, 8'd2, 8'd0};
        for (int k = 0; k < 9; k++)
            chk(tag, (obs.size() > k) ? obs[k] : 8'hxx, ref9[k]);
    endtask

    initial begin
        int lag;
        int first11;
        logic [7:0] v217;
        logic [7:0] cexp;
        bus_a.in_valid = 1'b0;
        bus_a.in_data  = '0;
        bus_a.in_sync  = 1'b0;
        bus_a.deint    = 1'b0;
        bus_c.in_valid = 1'b0;
        bus_c.in_data  = '0;
        bus_c.in_sync  = 1'b0;
        bus_c.deint    = 1'b0;
        chk_b = 1'b0;
        #2;
        do_reset();

        // continuous 1..30, plus chained deinterleaver
        chk_b = 1'b1;
        for (int i = 1; i <= 30; i++)
            step(1'b1, 8'(i), i == 1, 1'b0);
        repeat (2) step(1'b0, 8'd0, 1'b0, 1'b0);
        chk_first9("s1_first9");
        chk("b_first_idx", b_first, E2E);

        // valid toggling every cycle
        do_reset();
        for (int i = 1; i <= 30; i++) begin
            step(1'b1, 8'(i), i == 1, 1'b0);
            step(1'b0, 8'd0, 1'b0, 1'b0);
        end
        chk_first9("s3_first9");
        chk("s3_b_first_idx", b_first, E2E);
        chk_b = 1'b0;

        // realign with sync on the 5th symbol
        do_reset();
        for (int i = 1; i <= 9; i++)
            step(1'b1, 8'(i), i == 1 || i == 5, 1'b0);
        chk("s4_br5", obr[4], 0);
        chk("s4_sync5", osy[4], 1);
        chk("s4_br6", obr[5], 1);
        chk("s4_d9", obs[8], 2);

        // reset mid-stream, resume from 11
        do_reset();
        for (int i = 1; i <= 10; i++)
            step(1'b1, 8'(i), i == 1, 1'b0);
        do_reset();
        for (int i = 11; i <= 30; i++)
            step(1'b1, 8'(i), i == 11, 1'b0);
        chk("s5_o0", obs[0], 11);
        chk("s5_o1", obs[1], 0);
        chk("s5_o2", obs[2], 0);
        chk("s5_o3", obs[3], 14);

        // random interleave with gaps and stray syncs
        do_reset();
        for (int i = 0; i < 400; i++)
            step(($urandom % 4) != 0, 8'($urandom),
                 ($urandom % 12) == 0, 1'b0);

        // random deinterleave
        do_reset();
        step(1'b1, 8'($urandom), 1'b1, 1'b1);
        for (int i = 0; i < 400; i++)
            step(($urandom % 4) != 0, 8'($urandom),
                 ($urandom % 12) == 0, 1'b1);

        // default parameters: fill and lag
        do_reset();
        first11 = -1;
        v217 = 8'hxx;
        for (int k = 0; k < 2400; k++) begin
            bus_c.in_valid = 1'b1;
            bus_c.in_data  = 8'(k % 256);
            bus_c.in_sync  = (k == 0);
            @(posedge clk);
            #1;
            lag  = (k % 12) * 17 * 12;
            cexp = (k >= lag) ? 8'((k - lag) % 256) : 8'd0;
            chk("c_valid", bus_c.out_valid, 1);
            chk("c_data", bus_c.out_data, cexp);
            chk("c_branch", bus_c.out_branch, k % 12);
            if ((k % 12) == 11 && bus_c.out_data != 0 && first11 < 0)
                first11 = k;
            if (k == 217)
                v217 = bus_c.out_data;
        end
        bus_c.in_valid = 1'b0;
        bus_c.in_sync  = 1'b0;
        chk("c_b11_first", first11, 11 + 2244);
        chk("c_b1_lag", v217, 13);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
